// File: rtl/fwlight_btn_ctrl_pkg.sv
// Shared definitions for the flowing-light button controller: debounce FSM
// encoding and board-rate timing defaults.
package fwlight_btn_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_e;

    localparam int DEBOUNCE_CYCLES_DEF   = 2000000;    // 20 ms at 100 MHz
    localparam int LONG_PRESS_CYCLES_DEF = 100000000;  // 1 s at 100 MHz
    localparam int CNT_W_DEF             = 27;

endpackage

// File: rtl/fwlight_btn_ctrl_debounce.sv
// One push-button: 2-FF synchroniser, debounce FSM and long-press detector.
// Emits registered one-cycle press and long_press pulses.
module btn_debounce
    import fwlight_btn_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEF,
    parameter int LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEF,
    parameter int CNT_W             = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press,
    output logic long_press
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);

    logic             s_meta, s;
    btn_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] hold_cnt, hold_nxt;
    logic             long_fired, fired_nxt;
    logic             press_nxt, long_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            s_meta     <= 1'b0;
            s          <= 1'b0;
            state      <= IDLE;
            cnt        <= '0;
            hold_cnt   <= '0;
            long_fired <= 1'b0;
            press      <= 1'b0;
            long_press <= 1'b0;
        end else begin
            s_meta     <= btn;
            s          <= s_meta;
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            hold_cnt   <= hold_nxt;
            long_fired <= fired_nxt;
            press      <= press_nxt;
            long_press <= long_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        hold_nxt  = hold_cnt;
        fired_nxt = long_fired;
        press_nxt = 1'b0;
        long_nxt  = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt   = '0;
                hold_nxt  = '0;
                fired_nxt = 1'b0;
                if (s) state_nxt = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == DB_LAST) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                    press_nxt = 1'b1;
                end
            end
            PRESSED: begin
                cnt_nxt = '0;
                if (!s) begin
                    state_nxt = RELEASE_WAIT;
                end else begin
                    if (hold_cnt != LP_LAST) hold_nxt = hold_cnt + 1'b1;
                    // long fires on the cycle the saturated value is reached, once per press
                    if (hold_nxt == LP_LAST && !long_fired) begin
                        long_nxt  = 1'b1;
                        fired_nxt = 1'b1;
                    end
                end
            end
            RELEASE_WAIT: begin
                if (s) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt == DB_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    hold_nxt  = '0;
                    fired_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/fwlight_btn_ctrl.sv
// Button front end for the flowing-light block: turns debounced en/dir
// button events into en/direction levels and a one-cycle restart pulse.
module fwlight_btn_ctrl
    import fwlight_btn_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEF,
    parameter int LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEF,
    parameter int CNT_W             = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_en,
    input  logic btn_dir,
    output logic en,
    output logic direction,
    output logic restart
);

    logic en_press, en_long;
    logic dir_press, dir_long_unused;  // dir long-press has no function

    btn_debounce #(
        .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
        .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
        .CNT_W            (CNT_W)
    ) u_en (
        .clk       (clk),
        .reset     (reset),
        .btn       (btn_en),
        .press     (en_press),
        .long_press(en_long)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
        .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
        .CNT_W            (CNT_W)
    ) u_dir (
        .clk       (clk),
        .reset     (reset),
        .btn       (btn_dir),
        .press     (dir_press),
        .long_press(dir_long_unused)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            en        <= 1'b1;
            direction <= 1'b1;
            restart   <= 1'b0;
        end else begin
            restart <= en_long;
            if (dir_press) direction <= ~direction;
            // a long press forces the light back on, overriding any toggle
            if (en_long)       en <= 1'b1;
            else if (en_press) en <= ~en;
        end
    end

endmodule

// File: tb/tb_fwlight_btn_ctrl.sv
// Randomised and directed checks of fwlight_btn_ctrl against a run-length
// reference model of debounce / long-press behaviour.
module tb_fwlight_btn_ctrl;

    localparam int D = 4;
    localparam int L = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_en = 1'b0;
    logic btn_dir = 1'b0;
    logic en, direction, restart;

    int total = 0;
    int bad = 0;

    fwlight_btn_ctrl #(
        .DEBOUNCE_CYCLES  (D),
        .LONG_PRESS_CYCLES(L),
        .CNT_W            (5)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_en   (btn_en),
        .btn_dir  (btn_dir),
        .en       (en),
        .direction(direction),
        .restart  (restart)
    );

    always #5 clk = ~clk;

    // Reference model. Index 0 = en button, 1 = dir button.
    // A button's accepted level flips once the synchronised input has
    // disagreed with it for D+1 consecutive samples. Held time accrues on
    // samples where the button was already accepted and seen high twice running.
    logic       m_en = 1'b1, m_dir = 1'b1, m_rst = 1'b0;
    logic [1:0] sy1 = '0, sy2 = '0, prv = '0, acc = '0;
    logic [1:0] pend_press = '0, pend_long = '0, fired = '0;
    int         run [2];
    int         held[2];
    logic       ms;

    always @(posedge clk) begin
        if (reset) begin
            m_en = 1'b1; m_dir = 1'b1; m_rst = 1'b0;
            sy1 = '0; sy2 = '0; prv = '0; acc = '0;
            pend_press = '0; pend_long = '0; fired = '0;
            for (int b = 0; b < 2; b++) begin run[b] = 0; held[b] = 0; end
        end else begin
            m_rst = pend_long[0];
            if (pend_press[1]) m_dir = ~m_dir;
            if (pend_long[0]) m_en = 1'b1;
            else if (pend_press[0]) m_en = ~m_en;
            pend_press = '0;
            pend_long  = '0;
            for (int b = 0; b < 2; b++) begin
                ms = sy2[b];
                if (acc[b] && ms && prv[b]) begin
                    if (held[b] < L - 1) held[b]++;
                    if (held[b] == L - 1 && !fired[b]) begin
                        pend_long[b] = 1'b1;
                        fired[b]     = 1'b1;
                    end
                end
                if (ms != acc[b]) run[b]++; else run[b] = 0;
                if (run[b] == D + 1) begin
                    acc[b] = ms;
                    run[b] = 0;
                    if (ms) pend_press[b] = 1'b1;
                    else begin held[b] = 0; fired[b] = 1'b0; end
                end
                prv[b] = ms;
            end
            sy2 = sy1;
            sy1 = {btn_dir, btn_en};
        end
    end

    task automatic test_reset();
        reset = 1'b1; btn_en = 1'b0; btn_dir = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if ({en, direction, restart} !== 3'b110) begin
                bad++;
                $display("FAIL reset_vals got=%b want=110", {en, direction, restart});
            end
        end
        reset = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            total++;
            if ({en, direction, restart} !== 3'b110 || {m_en, m_dir, m_rst} !== 3'b110) begin
                bad++;
                $display("FAIL idle_after_reset cyc=%0d got=%b want=110", k, {en, direction, restart});
            end
        end
    endtask

    task automatic test_dir_press();
        logic start;
        for (int rep = 0; rep < 2; rep++) begin
            start = direction;
            btn_dir = 1'b1;
            for (int k = 0; k < 40; k++) begin
                if (k == 20) btn_dir = 1'b0;
                @(negedge clk);
                total++;
                if ({en, direction, restart} !== {m_en, m_dir, m_rst}) begin
                    bad++;
                    $display("FAIL dir_press_model k=%0d got=%b want=%b", k, {en, direction, restart}, {m_en, m_dir, m_rst});
                end
                if (k == 6 && direction !== start) begin
                    bad++;
                    $display("FAIL dir_early_toggle got=%b want=%b", direction, start);
                end
                if (k == 7) begin
                    total++;
                    if (direction !== ~start) begin
                        bad++;
                        $display("FAIL dir_toggle_edge7 got=%b want=%b", direction, ~start);
                    end
                end
            end
            total++;
            if (direction !== ~start) begin
                bad++;
                $display("FAIL dir_final rep=%0d got=%b want=%b", rep, direction, ~start);
            end
        end
    endtask

    task automatic test_glitch();
        int hi_len;
        for (int rep = 0; rep < 2; rep++) begin
            hi_len = (rep == 0) ? 3 : 8;
            btn_en = 1'b1;
            for (int k = 0; k < hi_len + 20; k++) begin
                if (k == hi_len) btn_en = 1'b0;
                @(negedge clk);
                total++;
                if ({en, direction, restart} !== {m_en, m_dir, m_rst}) begin
                    bad++;
                    $display("FAIL glitch_model k=%0d got=%b want=%b", k, {en, direction, restart}, {m_en, m_dir, m_rst});
                end
                if (rep == 0 && (en !== 1'b1 || restart !== 1'b0)) begin
                    bad++;
                    $display("FAIL glitch_rejected k=%0d en=%b restart=%b want en=1 restart=0", k, en, restart);
                end
            end
            total++;
            if (en !== (rep == 0)) begin
                bad++;
                $display("FAIL glitch_final rep=%0d en=%b want=%0d", rep, en, rep == 0);
            end
        end
    endtask

    task automatic test_long_press();
        int n_rst;
        logic saw_off;
        // restore en=1 with a plain press first
        btn_en = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (k == 10) btn_en = 1'b0;
            @(negedge clk);
        end
        total++;
        if (en !== 1'b1) begin
            bad++;
            $display("FAIL long_precondition en=%b want=1", en);
        end
        n_rst = 0; saw_off = 1'b0;
        btn_en = 1'b1;
        for (int k = 0; k < 50; k++) begin
            if (k == 30) btn_en = 1'b0;
            @(negedge clk);
            if (restart === 1'b1) n_rst++;
            if (en === 1'b0) saw_off = 1'b1;
            total++;
            if ({en, direction, restart} !== {m_en, m_dir, m_rst}) begin
                bad++;
                $display("FAIL long_model k=%0d got=%b want=%b", k, {en, direction, restart}, {m_en, m_dir, m_rst});
            end
            if (k == 16) begin
                total++;
                if (restart !== 1'b1 || en !== 1'b1) begin
                    bad++;
                    $display("FAIL long_restart_edge16 restart=%b en=%b want 1 1", restart, en);
                end
            end
        end
        total++;
        if (n_rst != 1 || !saw_off || en !== 1'b1) begin
            bad++;
            $display("FAIL long_summary restarts=%0d saw_off=%b en=%b want 1 1 1", n_rst, saw_off, en);
        end
    endtask

    task automatic test_dir_bounce();
        int toggles;
        logic last;
        toggles = 0; last = direction;
        btn_dir = 1'b1;
        for (int k = 0; k < 80; k++) begin
            case (k)
                12: btn_dir = 1'b0;
                14: btn_dir = 1'b1;
                24: btn_dir = 1'b0;
                44: btn_dir = 1'b1;
                54: btn_dir = 1'b0;
                default: ;
            endcase
            @(negedge clk);
            if (direction !== last) toggles++;
            last = direction;
            total++;
            if ({en, direction, restart} !== {m_en, m_dir, m_rst}) begin
                bad++;
                $display("FAIL bounce_model k=%0d got=%b want=%b", k, {en, direction, restart}, {m_en, m_dir, m_rst});
            end
            if (k == 43) begin
                total++;
                if (toggles != 1) begin
                    bad++;
                    $display("FAIL bounce_no_retrigger toggles=%0d want=1", toggles);
                end
            end
        end
        total++;
        if (toggles != 2) begin
            bad++;
            $display("FAIL bounce_second_press toggles=%0d want=2", toggles);
        end
    endtask

    task automatic test_reset_mid_press();
        // force en=0 beforehand so the reset back to en=1 is visible
        btn_en = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (k == 10) btn_en = 1'b0;
            @(negedge clk);
        end
        btn_en = 1'b1;
        for (int k = 0; k < 4; k++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++;
        if ({en, direction, restart} !== 3'b110) begin
            bad++;
            $display("FAIL midreset_vals got=%b want=110", {en, direction, restart});
        end
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            total++;
            if ({en, direction, restart} !== {m_en, m_dir, m_rst}) begin
                bad++;
                $display("FAIL midreset_model k=%0d got=%b want=%b", k, {en, direction, restart}, {m_en, m_dir, m_rst});
            end
            if (k == D + 3 && en !== 1'b1) begin
                bad++;
                $display("FAIL midreset_early en=%b want=1", en);
            end
            if (k == D + 4) begin
                total++;
                if (en !== 1'b0) begin
                    bad++;
                    $display("FAIL midreset_press en=%b want=0", en);
                end
            end
        end
        btn_en = 1'b0;
        for (int k = 0; k < 20; k++) @(negedge clk);
    endtask

    task automatic test_random();
        int len_en, len_dir;
        len_en = 0; len_dir = 0;
        for (int k = 0; k < 3000; k++) begin
            if (len_en == 0) begin
                btn_en = $urandom_range(0, 1);
                len_en = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 25) : $urandom_range(1, 8);
            end
            if (len_dir == 0) begin
                btn_dir = $urandom_range(0, 1);
                len_dir = $urandom_range(1, 12);
            end
            len_en--; len_dir--;
            reset = ($urandom_range(0, 299) == 0);
            @(negedge clk);
            total++;
            if ({en, direction, restart} !== {m_en, m_dir, m_rst}) begin
                bad++;
                $display("FAIL random_model k=%0d got=%b want=%b", k, {en, direction, restart}, {m_en, m_dir, m_rst});
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_dir_press();
        test_glitch();
        test_long_press();
        test_dir_bounce();
        test_reset_mid_press();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
